// File: rtl/eth_idma_req_sched.sv
// rtl/eth_idma_req_sched.sv - round-robin iDMA descriptor scheduler with in-order response routing
module eth_idma_req_sched #(
    parameter int unsigned NumChannels    = 2,
    parameter int unsigned QueueDepth     = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned DescWidth      = 128,
    parameter int unsigned DoneCntWidth   = 8,
    localparam int unsigned ChW = (NumChannels > 1) ? $clog2(NumChannels) : 1,
    localparam int unsigned FW  = $clog2(QueueDepth) + 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                clear_i,
    input  logic [NumChannels-1:0]              chan_enable_i,
    input  logic                                push_valid_i,
    output logic                                push_ready_o,
    input  logic [ChW-1:0]                      push_chan_i,
    input  logic [DescWidth-1:0]                push_desc_i,
    output logic [DescWidth-1:0]                idma_req_o,
    output logic                                idma_req_valid_o,
    input  logic                                idma_req_ready_i,
    input  logic                                idma_rsp_valid_i,
    output logic                                idma_rsp_ready_o,
    input  logic                                idma_rsp_error_i,
    input  logic [DoneCntWidth-1:0]             irq_thresh_i,
    input  logic [NumChannels-1:0]              done_ack_i,
    output logic [NumChannels*DoneCntWidth-1:0] done_cnt_o,
    output logic [NumChannels*FW-1:0]           fill_o,
    output logic [NumChannels-1:0]              irq_o,
    output logic [NumChannels-1:0]              err_o,
    output logic                                busy_o
);
    localparam int unsigned QAW = $clog2(QueueDepth);
    localparam int unsigned TAW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned OW  = $clog2(MaxOutstanding) + 1;

    logic [DescWidth-1:0]    mem_q    [NumChannels][QueueDepth];
    logic [QAW-1:0]          wr_ptr_q [NumChannels];
    logic [QAW-1:0]          rd_ptr_q [NumChannels];
    logic [FW-1:0]           fill_q   [NumChannels];
    logic [ChW-1:0]          tag_q    [MaxOutstanding];
    logic [TAW-1:0]          tag_wr_q, tag_rd_q;
    logic [OW-1:0]           tag_cnt_q;
    logic                    valid_q;
    logic [DescWidth-1:0]    req_q;
    logic [ChW-1:0]          rr_q;
    logic [DoneCntWidth-1:0] done_q   [NumChannels];
    logic [NumChannels-1:0]  err_q, irq_q;

    logic                    push_in_range, push_hs, rsp_hs, load_en, grant_vld;
    logic [ChW-1:0]          grant_ch, rsp_ch;
    logic [NumChannels-1:0]  elig, nonempty, push_sel, pop_sel;
    int unsigned             arb_idx;

    function automatic logic [TAW-1:0] tag_inc(input logic [TAW-1:0] p);
        return (p == TAW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push_in_range = (32'(push_chan_i) < NumChannels);
    assign push_ready_o  = !clear_i && push_in_range && (fill_q[push_chan_i] != FW'(QueueDepth));
    assign push_hs       = push_valid_i && push_ready_o;
    assign rsp_hs        = idma_rsp_valid_i && (tag_cnt_q != '0);
    assign rsp_ch        = tag_q[tag_rd_q];
    // The output register refills on the same edge it hands off, giving one request per cycle.
    assign load_en       = !clear_i && (!valid_q || idma_req_ready_i) && grant_vld;

    always_comb begin
        elig     = '0;
        nonempty = '0;
        push_sel = '0;
        pop_sel  = '0;
        for (int k = 0; k < NumChannels; k++) begin
            nonempty[k] = (fill_q[k] != '0);
            elig[k]     = nonempty[k] && chan_enable_i[k] && (tag_cnt_q < OW'(MaxOutstanding));
            push_sel[k] = push_hs && (push_chan_i == ChW'(k));
            pop_sel[k]  = load_en && (grant_ch == ChW'(k));
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        arb_idx   = 0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            arb_idx = 32'(rr_q) + i;
            if (arb_idx >= NumChannels) arb_idx = arb_idx - NumChannels;
            if (!grant_vld && elig[arb_idx[ChW-1:0]]) begin
                grant_vld = 1'b1;
                grant_ch  = arb_idx[ChW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NumChannels; k++) begin
            if (push_sel[k]) mem_q[k][wr_ptr_q[k]] <= push_desc_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumChannels; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                fill_q[k]   <= '0;
            end
        end else if (clear_i) begin
            for (int k = 0; k < NumChannels; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                fill_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NumChannels; k++) begin
                if (push_sel[k]) wr_ptr_q[k] <= wr_ptr_q[k] + 1'b1;
                if (pop_sel[k])  rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
                fill_q[k] <= fill_q[k] + FW'(push_sel[k]) - FW'(pop_sel[k]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            req_q     <= '0;
            rr_q      <= '0;
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            tag_cnt_q <= '0;
            err_q     <= '0;
            irq_q     <= '0;
            for (int t = 0; t < MaxOutstanding; t++) tag_q[t] <= '0;
            for (int k = 0; k < NumChannels; k++) done_q[k] <= '0;
        end else begin
            if (load_en) begin
                valid_q         <= 1'b1;
                req_q           <= mem_q[grant_ch][rd_ptr_q[grant_ch]];
                rr_q            <= (grant_ch == ChW'(NumChannels - 1)) ? '0 : grant_ch + 1'b1;
                tag_q[tag_wr_q] <= grant_ch;
                tag_wr_q        <= tag_inc(tag_wr_q);
            end else if (idma_req_ready_i) begin
                valid_q <= 1'b0;
            end
            if (rsp_hs) tag_rd_q <= tag_inc(tag_rd_q);
            tag_cnt_q <= tag_cnt_q + OW'(load_en) - OW'(rsp_hs);
            for (int k = 0; k < NumChannels; k++) begin
                // An acknowledge landing with a completion restarts the count at that completion.
                if (rsp_hs && (rsp_ch == ChW'(k))) begin
                    if (done_ack_i[k]) begin
                        done_q[k] <= DoneCntWidth'(1);
                        err_q[k]  <= idma_rsp_error_i;
                    end else begin
                        if (done_q[k] != '1) done_q[k] <= done_q[k] + 1'b1;
                        err_q[k] <= err_q[k] | idma_rsp_error_i;
                    end
                end else if (done_ack_i[k]) begin
                    done_q[k] <= '0;
                    err_q[k]  <= 1'b0;
                end
                irq_q[k] <= (irq_thresh_i != '0) && (done_q[k] >= irq_thresh_i);
            end
        end
    end

    always_comb begin
        done_cnt_o = '0;
        fill_o     = '0;
        for (int k = 0; k < NumChannels; k++) begin
            done_cnt_o[k*DoneCntWidth +: DoneCntWidth] = done_q[k];
            fill_o[k*FW +: FW]                         = fill_q[k];
        end
    end

    assign idma_req_o       = req_q;
    assign idma_req_valid_o = valid_q;
    assign idma_rsp_ready_o = (tag_cnt_q != '0);
    assign irq_o            = irq_q;
    assign err_o            = err_q;
    assign busy_o           = (|nonempty) || valid_q || (tag_cnt_q != '0);

    rsp_has_tag: assert property (@(posedge clk_i) disable iff (!rst_ni)
        idma_rsp_valid_i |-> (tag_cnt_q != '0));

endmodule

// File: tb/tb_eth_idma_req_sched.sv
// tb/tb_eth_idma_req_sched.sv - randomized and directed checks against a queue-based reference model
module tb_eth_idma_req_sched;
    localparam int NC = 2;
    localparam int QD = 4;
    localparam int MO = 4;
    localparam int DW = 32;
    localparam int CW = 2;
    localparam int FW = 3;
    localparam int SAT = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clear, push_valid, push_ready, push_chan;
    logic [DW-1:0]   push_desc, req;
    logic [NC-1:0]   chan_en, done_ack, irq, err;
    logic            req_valid, req_ready, rsp_valid, rsp_ready, rsp_error, busy;
    logic [CW-1:0]   thresh;
    logic [NC*CW-1:0] done_cnt;
    logic [NC*FW-1:0] fill;

    int checks = 0;
    int passed = 0;
    int dut_hs = 0;

    logic [DW-1:0] mq [NC][$];
    int            mtags [$];
    bit            mout_valid;
    logic [DW-1:0] mout_desc;
    int            mrr;
    int            mdone [NC];
    bit            merr [NC];
    bit            mirq [NC];

    always #5 clk = ~clk;

    eth_idma_req_sched #(
        .NumChannels(NC), .QueueDepth(QD), .MaxOutstanding(MO),
        .DescWidth(DW), .DoneCntWidth(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .chan_enable_i(chan_en),
        .push_valid_i(push_valid), .push_ready_o(push_ready), .push_chan_i(push_chan),
        .push_desc_i(push_desc), .idma_req_o(req), .idma_req_valid_o(req_valid),
        .idma_req_ready_i(req_ready), .idma_rsp_valid_i(rsp_valid), .idma_rsp_ready_o(rsp_ready),
        .idma_rsp_error_i(rsp_error), .irq_thresh_i(thresh), .done_ack_i(done_ack),
        .done_cnt_o(done_cnt), .fill_o(fill), .irq_o(irq), .err_o(err), .busy_o(busy)
    );

    function automatic bit model_busy();
        bit b = mout_valid || (mtags.size() > 0);
        for (int k = 0; k < NC; k++) if (mq[k].size() > 0) b = 1;
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            mq[k].delete();
            mdone[k] = 0;
            merr[k]  = 0;
            mirq[k]  = 0;
        end
        mtags.delete();
        mout_valid = 0;
        mout_desc  = '0;
        mrr        = 0;
    endtask

    task automatic zero_inputs();
        clear = 0; push_valid = 0; push_chan = 0; push_desc = '0; chan_en = '0;
        req_ready = 0; rsp_valid = 0; rsp_error = 0; thresh = '0; done_ack = '0;
    endtask

    task automatic apply_reset();
        zero_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        model_reset();
    endtask

    // Advances one clock: the model applies the scheduling rules to the inputs present before the edge.
    task automatic tick();
        bit push_ok, rsp_hs, load;
        int w, rch;
        if (req_valid === 1'b1 && req_ready === 1'b1) dut_hs++;
        push_ok = push_valid && !clear && (int'(push_chan) < NC) && (mq[push_chan].size() < QD);
        rsp_hs  = rsp_valid && (mtags.size() > 0);
        load = 0;
        w    = 0;
        if (!clear && (!mout_valid || req_ready)) begin
            for (int i = 0; i < NC; i++) begin
                int c;
                c = (mrr + i) % NC;
                if (!load && mq[c].size() > 0 && chan_en[c] && mtags.size() < MO) begin
                    load = 1;
                    w    = c;
                end
            end
        end
        for (int k = 0; k < NC; k++) mirq[k] = (thresh != 0) && (mdone[k] >= int'(thresh));
        rch = -1;
        if (rsp_hs) rch = mtags.pop_front();
        for (int k = 0; k < NC; k++) begin
            if (rch == k) begin
                if (done_ack[k]) begin
                    mdone[k] = 1;
                    merr[k]  = rsp_error;
                end else begin
                    if (mdone[k] < SAT) mdone[k]++;
                    merr[k] = merr[k] | rsp_error;
                end
            end else if (done_ack[k]) begin
                mdone[k] = 0;
                merr[k]  = 0;
            end
        end
        if (load) begin
            mout_desc  = mq[w].pop_front();
            mout_valid = 1;
            mtags.push_back(w);
            mrr = (w + 1) % NC;
        end else if (mout_valid && req_ready) begin
            mout_valid = 0;
        end
        if (clear) for (int k = 0; k < NC; k++) mq[k].delete();
        if (push_ok) mq[push_chan].push_back(push_desc);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_ready  = 1;
        push_valid = 0;
        for (int i = 0; i < 40 && model_busy(); i++) begin
            rsp_valid = (mtags.size() > 0);
            tick();
        end
        rsp_valid = 0;
        rsp_error = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({req_valid, rsp_ready, busy} !== 3'b000) $display("FAIL reset_flags got=%b want=000", {req_valid, rsp_ready, busy});
        else passed++;
        checks++;
        if (req !== '0) $display("FAIL reset_req got=%h want=0", req);
        else passed++;
        checks++;
        if ({done_cnt, fill, irq, err} !== '0) $display("FAIL reset_counters got=%h want=0", {done_cnt, fill, irq, err});
        else passed++;
        push_chan = 0;
        #1;
        checks++;
        if (push_ready !== 1'b1) $display("FAIL reset_push_ready got=%b want=1", push_ready);
        else passed++;
    endtask

    task automatic test_basic();
        chan_en = 2'b11; req_ready = 1; thresh = 2'd1;
        push_chan = 0; push_desc = 32'hA5; push_valid = 1;
        tick();
        push_valid = 0;
        checks++;
        if (req_valid !== 1'b0 || fill[FW-1:0] !== 3'd1) $display("FAIL basic_no_fallthrough valid=%b fill=%0d want valid=0 fill=1", req_valid, fill[FW-1:0]);
        else passed++;
        tick();
        checks++;
        if (req_valid !== 1'b1 || req !== 32'hA5) $display("FAIL basic_issue valid=%b req=%h want 1/a5", req_valid, req);
        else passed++;
        tick();
        checks++;
        if (req_valid !== 1'b0 || rsp_ready !== 1'b1) $display("FAIL basic_handoff valid=%b rsp_ready=%b want 0/1", req_valid, rsp_ready);
        else passed++;
        rsp_valid = 1;
        tick();
        rsp_valid = 0;
        checks++;
        if (done_cnt[CW-1:0] !== 2'd1 || rsp_ready !== 1'b0) $display("FAIL basic_done got=%0d rsp_ready=%b want 1/0", done_cnt[CW-1:0], rsp_ready);
        else passed++;
        tick();
        checks++;
        if (irq !== 2'b01) $display("FAIL basic_irq got=%b want=01", irq);
        else passed++;
        done_ack = 2'b01;
        tick();
        done_ack = '0;
        tick();
        checks++;
        if (done_cnt !== '0 || irq !== 2'b00) $display("FAIL basic_ack done=%h irq=%b want 0/00", done_cnt, irq);
        else passed++;
        thresh = '0;
    endtask

    task automatic test_round_robin();
        apply_reset();
        req_ready = 1;
        for (int i = 0; i < 6; i++) begin
            push_valid = 1; push_chan = 1'(i % 2); push_desc = 32'h100 + i;
            tick();
        end
        push_valid = 0;
        chan_en = 2'b11;
        for (int j = 0; j < 6; j++) begin
            rsp_valid = (mtags.size() > 0);
            tick();
            checks++;
            if (req_valid !== 1'b1 || req !== 32'h100 + j) $display("FAIL rr_order slot=%0d valid=%b req=%h want 1/%h", j, req_valid, req, 32'h100 + j);
            else passed++;
        end
        drain();
    endtask

    task automatic test_backpressure();
        int hs0;
        logic [DW-1:0] d;
        d = $urandom;
        chan_en = 2'b11; req_ready = 0;
        push_valid = 1; push_chan = 1; push_desc = d;
        tick();
        push_valid = 0;
        tick();
        hs0 = dut_hs;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (req_valid !== 1'b1 || req !== d) $display("FAIL bp_stable cyc=%0d valid=%b req=%h want 1/%h", i, req_valid, req, d);
            else passed++;
            tick();
        end
        req_ready = 1;
        tick();
        checks++;
        if (req_valid !== 1'b0 || dut_hs - hs0 !== 1) $display("FAIL bp_single_hs valid=%b hs=%0d want 0/1", req_valid, dut_hs - hs0);
        else passed++;
        drain();
    endtask

    task automatic test_outstanding();
        int hs0;
        bit pattern [6] = '{1, 0, 1, 1, 0, 1};
        apply_reset();
        chan_en = 2'b11; req_ready = 1;
        hs0 = dut_hs;
        for (int i = 0; i < 6; i++) begin
            push_valid = 1; push_chan = pattern[i]; push_desc = $urandom;
            tick();
        end
        push_valid = 0;
        repeat (4) tick();
        checks++;
        if (dut_hs - hs0 !== 4 || req_valid !== 1'b0) $display("FAIL outst_limit hs=%0d valid=%b want 4/0", dut_hs - hs0, req_valid);
        else passed++;
        checks++;
        if (fill !== {3'd1, 3'd1} || rsp_ready !== 1'b1) $display("FAIL outst_waiting fill=%h rsp_ready=%b want 09/1", fill, rsp_ready);
        else passed++;
        for (int j = 0; j < 4; j++) begin
            rsp_valid = 1; rsp_error = (j == 1);
            tick();
        end
        rsp_valid = 0; rsp_error = 0;
        checks++;
        if (done_cnt !== {2'd3, 2'd1}) $display("FAIL outst_routing got=%h want=d", done_cnt);
        else passed++;
        checks++;
        if (err !== 2'b01) $display("FAIL outst_err got=%b want=01", err);
        else passed++;
        drain();
    endtask

    task automatic test_full_clear_ack();
        apply_reset();
        chan_en = 2'b01; req_ready = 1;
        push_valid = 1; push_chan = 0; push_desc = $urandom;
        tick();
        drain();
        chan_en = 2'b00;
        for (int i = 0; i < QD; i++) begin
            push_valid = 1; push_chan = 0; push_desc = $urandom;
            tick();
        end
        push_valid = 0; push_chan = 0;
        #1;
        checks++;
        if (push_ready !== 1'b0) $display("FAIL full_ch0 got=%b want=0", push_ready);
        else passed++;
        push_chan = 1;
        #1;
        checks++;
        if (push_ready !== 1'b1) $display("FAIL full_ch1 got=%b want=1", push_ready);
        else passed++;
        chan_en = 2'b01; req_ready = 0;
        tick();
        clear = 1;
        #1;
        checks++;
        if (push_ready !== 1'b0) $display("FAIL clear_push_ready got=%b want=0", push_ready);
        else passed++;
        tick();
        clear = 0;
        checks++;
        if (fill !== '0 || req_valid !== 1'b1 || busy !== 1'b1) $display("FAIL clear_state fill=%h valid=%b busy=%b want 0/1/1", fill, req_valid, busy);
        else passed++;
        req_ready = 1;
        tick();
        checks++;
        if (req_valid !== 1'b0 || busy !== 1'b1) $display("FAIL clear_inflight valid=%b busy=%b want 0/1", req_valid, busy);
        else passed++;
        rsp_valid = 1; rsp_error = 1; done_ack = 2'b01;
        tick();
        rsp_valid = 0; rsp_error = 0; done_ack = '0;
        checks++;
        if (done_cnt[CW-1:0] !== 2'd1 || err[0] !== 1'b1 || busy !== 1'b0) $display("FAIL ack_coincide done=%0d err=%b busy=%b want 1/1/0", done_cnt[CW-1:0], err[0], busy);
        else passed++;
    endtask

    task automatic test_saturation();
        done_ack = 2'b11;
        tick();
        done_ack = '0;
        chan_en = 2'b11; req_ready = 1; thresh = 2'd3;
        for (int i = 0; i < 5; i++) begin
            push_valid = 1; push_chan = 1; push_desc = $urandom;
            rsp_valid = (mtags.size() > 0);
            tick();
        end
        drain();
        tick();
        checks++;
        if (done_cnt[2*CW-1:CW] !== 2'd3) $display("FAIL sat_count got=%0d want=3", done_cnt[2*CW-1:CW]);
        else passed++;
        checks++;
        if (irq !== 2'b10) $display("FAIL sat_irq got=%b want=10", irq);
        else passed++;
    endtask

    task automatic test_random();
        logic [NC*FW-1:0] ef;
        logic [NC*CW-1:0] ed;
        logic [NC-1:0]    ee, ei;
        for (int n = 0; n < 600; n++) begin
            push_valid = 1'($urandom_range(0, 1));
            push_chan  = 1'($urandom_range(0, 1));
            push_desc  = $urandom;
            if ($urandom_range(0, 15) == 0) chan_en = ($urandom_range(0, 2) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
            req_ready = ($urandom_range(0, 3) != 0);
            rsp_valid = (mtags.size() > 0) && ($urandom_range(0, 2) != 0);
            rsp_error = ($urandom_range(0, 7) == 0);
            done_ack  = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            clear     = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 31) == 0) thresh = 2'($urandom_range(0, 3));
            tick();
            for (int k = 0; k < NC; k++) begin
                ef[k*FW +: FW] = FW'(mq[k].size());
                ed[k*CW +: CW] = CW'(mdone[k]);
                ee[k] = merr[k];
                ei[k] = mirq[k];
            end
            checks++;
            if ({req_valid, rsp_ready, busy, fill, done_cnt, err, irq} !== {mout_valid, mtags.size() > 0, model_busy(), ef, ed, ee, ei})
                $display("FAIL rand_state cyc=%0d got=%h want=%h", n, {req_valid, rsp_ready, busy, fill, done_cnt, err, irq},
                         {mout_valid, mtags.size() > 0, model_busy(), ef, ed, ee, ei});
            else passed++;
            if (mout_valid) begin
                checks++;
                if (req !== mout_desc) $display("FAIL rand_req cyc=%0d got=%h want=%h", n, req, mout_desc);
                else passed++;
            end
        end
        zero_inputs();
        chan_en = 2'b11;
        drain();
    endtask

    task automatic test_reset_mid();
        chan_en = 2'b11; req_ready = 1; thresh = 2'd1;
        for (int i = 0; i < 4; i++) begin
            push_valid = 1; push_chan = 1'(i % 2); push_desc = $urandom;
            tick();
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({req_valid, rsp_ready, busy, irq, err, fill, done_cnt} !== '0 || req !== '0)
            $display("FAIL reset_async got=%h req=%h want=0", {req_valid, rsp_ready, busy, irq, err, fill, done_cnt}, req);
        else passed++;
        zero_inputs();
        #2 rst_n = 1;
        model_reset();
        chan_en = 2'b11; req_ready = 1;
        tick();
        checks++;
        if ({req_valid, rsp_ready, busy} !== 3'b000) $display("FAIL reset_no_replay got=%b want=000", {req_valid, rsp_ready, busy});
        else passed++;
    endtask

    initial begin
        zero_inputs();
        model_reset();
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_outstanding();
        test_full_clear_ack();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/eth_idma_req_sched.md
Name: eth_idma_req_sched

Overview:
- Multi-channel descriptor scheduler placed between the Ethernet register file and the iDMA backend. It replaces the single register-driven req_valid/rsp_ready pair.
- Software or a descriptor fetcher pushes opaque iDMA request words into per-channel queues (for example TX, RX, and loopback channels).
- The block arbitrates round-robin across channels, issues one request at a time on a valid/ready port, and tracks outstanding requests in order.
- It routes each backend response to its originating channel as a completion count, an interrupt and a sticky error flag.

Parameters:
- NumChannels, 2, number of independent descriptor queues (>=1).
- QueueDepth, 4, entries per channel queue (power of 2, >=2).
- MaxOutstanding, 4, maximum requests issued or pending without a response (power of 2, >=1).
- DescWidth, 128, width of the packed idma_req_t descriptor (opaque to this block).
- DoneCntWidth, 8, width of each per-channel completion counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush of all channel queues.
- chan_enable_i  in  NumChannels  per-channel arbitration enable.
- push_valid_i  in  1  descriptor push valid.
- push_ready_o  out  1  selected channel queue can accept the push.
- push_chan_i  in  $clog2(NumChannels) (min 1)  target channel.
- push_desc_i  in  DescWidth  descriptor.
- idma_req_o  out  DescWidth  request to the backend.
- idma_req_valid_o  out  1  request valid.
- idma_req_ready_i  in  1  backend accepts the request.
- idma_rsp_valid_i  in  1  backend response valid.
- idma_rsp_ready_o  out  1  response accepted.
- idma_rsp_error_i  in  1  response carries an error.
- irq_thresh_i  in  DoneCntWidth  shared interrupt threshold; 0 disables interrupts.
- done_ack_i  in  NumChannels  per-channel clear of the completion count and error flag.
- done_cnt_o  out  NumChannels*DoneCntWidth  per-channel completion counts.
- fill_o  out  NumChannels*($clog2(QueueDepth)+1)  per-channel queue fill levels.
- irq_o  out  NumChannels  per-channel interrupt.
- err_o  out  NumChannels  per-channel sticky error.
- busy_o  out  1  block holds any queued, pending or outstanding work.

Behaviour:
- Reset state:
  - All queues empty.
  - Output register invalid: idma_req_valid_o=0, idma_req_o=0.
  - Tag FIFO empty, so idma_rsp_ready_o=0.
  - Round-robin pointer=0.
  - done_cnt_o, irq_o, err_o, fill_o and busy_o all 0.
- Push:
  - push_ready_o = !clear_i && queue[push_chan_i] not full. This is combinational.
  - A push with push_chan_i >= NumChannels is dropped (push_ready_o=0).
  - The write occurs on the valid&&ready edge.
- Arbitration:
  - A channel is eligible when its queue is non-empty, chan_enable_i is high and the outstanding count is below MaxOutstanding.
  - The output register loads when it is empty, or in the same cycle it handshakes.
  - The winner is the first eligible channel searching from the round-robin pointer upward, mod NumChannels.
  - After a grant to channel k, the pointer becomes k+1 mod NumChannels.
- Latency and throughput:
  - A push at edge N makes idma_req_valid_o high after edge N+1 (two-cycle latency, no fall-through).
  - Back-to-back issue sustains one request per cycle.
- Output stability:
  - While idma_req_valid_o=1 and idma_req_ready_i=0, idma_req_o is held stable.
  - The valid signal does not drop until the handshake.
- Outstanding tracking:
  - On each output-register load, the channel index is pushed into a tag FIFO of depth MaxOutstanding.
  - The outstanding count therefore includes the pending request.
  - idma_rsp_ready_o = tag FIFO non-empty.
  - A response handshake pops the tag and credits that channel.
  - idma_rsp_valid_i with an empty tag FIFO is ignored; the simulation assertion flags it.
- Completion:
  - done_cnt[k] increments on each response for channel k and saturates at all-ones.
  - done_ack_i[k] clears done_cnt[k] and err[k].
  - If an acknowledge coincides with a completion on k, done_cnt[k]=1, and err[k] is taken from that response.
  - err[k] is set on a response for k with idma_rsp_error_i=1.
- Interrupt: irq_o[k] = (irq_thresh_i!=0) && done_cnt[k]>=irq_thresh_i. It is registered from the counter value, so it is a level signal.
- clear_i:
  - Empties all channel queues at the edge.
  - The output register and tag FIFO are untouched, so the in-flight request still handshakes and completes.
  - No load from the queues occurs in a clear cycle.
- chan_enable_i low: the channel is skipped by the arbiter, but pushes to it are still accepted.
- busy_o = any queue non-empty || idma_req_valid_o || tag FIFO non-empty.
- Reset mid-operation returns every state element to its reset value immediately (asynchronous); no response is replayed.

Test Plan:
- Basic issue and completion:
  - Stimulus: push desc 0xA5 to ch0, ready=1.
  - Required: idma_req_valid_o high 2 cycles later with idma_req_o=0xA5. A response one cycle later gives done_cnt[0]=1. With irq_thresh_i=1, irq_o[0]=1.
- Round-robin fairness:
  - Stimulus: NumChannels=2, push 3 descriptors to each channel before enabling, then enable both channels with ready=1.
  - Required: issue order ch0,ch1,ch0,ch1,ch0,ch1 on consecutive cycles, with no bubbles.
- Backpressure stability:
  - Stimulus: hold idma_req_ready_i=0 for 5 cycles.
  - Required: idma_req_o constant and valid high throughout; the handshake occurs exactly once.
- Outstanding limit and routing:
  - Stimulus: MaxOutstanding=4, withhold responses, queue 6 descriptors.
  - Required: exactly 4 issue and the 5th waits. Out-of-band responses return in order: channel pattern ch1,ch0,ch1,ch1 gives done_cnt={ch0:1, ch1:3}. An error on the 2nd response sets err_o[0] only.
- Full, clear and acknowledge:
  - Full: fill ch0 to QueueDepth; push_ready_o=0 for ch0 and 1 for ch1.
  - Clear: assert clear_i while one request is pending. Required: fill_o=0, the pending request completes, and busy_o falls after its response.
  - Acknowledge: assert done_ack_i[0] in the same cycle as a ch0 response. Required: done_cnt[0]=1.
- Saturation and reset:
  - Stimulus: DoneCntWidth=2, 5 completions on ch1.
  - Required: done_cnt[1]=3.
  - Stimulus: assert rst_ni low mid-burst.
  - Required: all outputs return to 0 asynchronously.
